// File: rtl/merge_fifo_nway.sv
// N-way merge of ascending sorted lists, one FIFO per channel, with optional
// collapsing of equal heads into one beat carrying a contributor mask and count.
module merge_fifo_nway #(
  parameter int unsigned DW               = 8,
  parameter int unsigned NCH              = 4,
  parameter int unsigned CHW              = 2,
  parameter int unsigned FIFO_DEPTH_WIDTH = 4,
  parameter bit          DEDUP            = 1'b1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NCH-1:0]                      i_valid,
  output logic [NCH-1:0]                      i_ready,
  input  logic [NCH-1:0]                      i_last,
  input  logic [NCH*DW-1:0]                   i_data,
  input  logic                                o_ready,
  output logic                                o_valid,
  output logic                                o_last,
  output logic [DW-1:0]                       o_data,
  output logic [CHW-1:0]                      o_ch,
  output logic [NCH-1:0]                      o_mask,
  output logic [CHW:0]                        o_cnt,
  output logic [NCH*(FIFO_DEPTH_WIDTH+1)-1:0] o_level
);

  localparam int unsigned Depth = 2 ** FIFO_DEPTH_WIDTH;
  localparam int unsigned LW    = FIFO_DEPTH_WIDTH + 1;

  typedef logic [FIFO_DEPTH_WIDTH-1:0] ptr_t;
  typedef logic [LW-1:0]               lvl_t;
  typedef logic [CHW-1:0]              ch_t;

  logic [DW:0]    mem_q [NCH][Depth];
  ptr_t           wr_ptr_q [NCH];
  ptr_t           wr_ptr_d [NCH];
  ptr_t           rd_ptr_q [NCH];
  ptr_t           rd_ptr_d [NCH];
  lvl_t           lvl_q [NCH];
  lvl_t           lvl_d [NCH];
  logic [DW-1:0]  head_data [NCH];
  logic [NCH-1:0] head_last, nonempty, push, pop, sel, remaining;
  logic [NCH-1:0] active_q, active_d;

  logic           fire, min_found, group_done;
  logic [DW-1:0]  min_val;
  ch_t            min_ch;
  logic [CHW:0]   sel_cnt;

  logic           o_valid_q, o_valid_d, o_last_q, o_last_d;
  logic [DW-1:0]  o_data_q, o_data_d;
  ch_t            o_ch_q, o_ch_d;
  logic [NCH-1:0] o_mask_q, o_mask_d;
  logic [CHW:0]   o_cnt_q, o_cnt_d;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      nonempty[c]  = (lvl_q[c] != '0);
      head_data[c] = mem_q[c][rd_ptr_q[c]][DW-1:0];
      head_last[c] = mem_q[c][rd_ptr_q[c]][DW];
      i_ready[c]   = reset & (lvl_q[c] != lvl_t'(Depth));
      push[c]      = i_valid[c] & i_ready[c];
    end
  end

  // Only active channels compete; an empty active channel blocks the merge so
  // that a smaller value still in flight can never be overtaken.
  always_comb begin
    min_found = 1'b0;
    min_val   = '0;
    min_ch    = '0;
    for (int c = 0; c < NCH; c++) begin
      if (active_q[c] && (!min_found || head_data[c] < min_val)) begin
        min_found = 1'b1;
        min_val   = head_data[c];
        min_ch    = ch_t'(c);
      end
    end
    sel_cnt = '0;
    for (int c = 0; c < NCH; c++) begin
      if (DEDUP) sel[c] = active_q[c] & (head_data[c] == min_val);
      else       sel[c] = min_found & (ch_t'(c) == min_ch);
      sel_cnt = sel_cnt + (CHW+1)'(sel[c]);
    end
    fire       = (!o_valid_q || o_ready) && min_found && ((nonempty | ~active_q) == '1);
    pop        = fire ? sel : '0;
    remaining  = active_q & ~(pop & head_last);
    group_done = (remaining == '0);
    active_d   = active_q;
    if (fire) active_d = group_done ? '1 : remaining;
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c] + ptr_t'(push[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + ptr_t'(pop[c]);
      lvl_d[c]    = lvl_q[c] + lvl_t'(push[c]) - lvl_t'(pop[c]);
    end
  end

  always_comb begin
    o_valid_d = o_valid_q;
    o_last_d  = o_last_q;
    o_data_d  = o_data_q;
    o_ch_d    = o_ch_q;
    o_mask_d  = o_mask_q;
    o_cnt_d   = o_cnt_q;
    if (fire) begin
      o_valid_d = 1'b1;
      o_last_d  = group_done;
      o_data_d  = min_val;
      o_ch_d    = min_ch;
      o_mask_d  = sel;
      o_cnt_d   = sel_cnt;
    end else if (o_ready) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (push[c]) mem_q[c][wr_ptr_q[c]] <= {i_last[c], i_data[c*DW +: DW]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        lvl_q[c]    <= '0;
      end
      active_q  <= '1;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      o_data_q  <= '0;
      o_ch_q    <= '0;
      o_mask_q  <= '0;
      o_cnt_q   <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        lvl_q[c]    <= lvl_d[c];
      end
      active_q  <= active_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      o_data_q  <= o_data_d;
      o_ch_q    <= o_ch_d;
      o_mask_q  <= o_mask_d;
      o_cnt_q   <= o_cnt_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_level
    assign o_level[g*LW +: LW] = lvl_q[g];
  end

  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;
  assign o_data  = o_data_q;
  assign o_ch    = o_ch_q;
  assign o_mask  = o_mask_q;
  assign o_cnt   = o_cnt_q;

endmodule

// File: tb/tb_merge_fifo_nway.sv
// Scoreboard bench: a = 4 channels dedup, b = 4 channels no dedup (same inputs),
// c = 2 channels dedup for the stall and group-boundary cases.
module tb_merge_fifo_nway;

  typedef struct packed {
    logic [7:0] d;
    logic [3:0] m;
    logic [2:0] n;
    logic [1:0] ch;
    logic       l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  v4, l4, ra, rb;
  logic [31:0] d4;
  logic [1:0]  v2, l2, rc;
  logic [15:0] d2;
  logic        ora, orb, orc;

  logic        va, la, vb, lb, vc, lc;
  logic [7:0]  da, db, dc;
  logic [1:0]  cha, chb;
  logic [0:0]  chc;
  logic [3:0]  ma, mb;
  logic [1:0]  mc, cc;
  logic [2:0]  ca, cb;
  logic [19:0] lva, lvb;
  logic [9:0]  lvc;

  beat_t      qa[$], qb[$], qc[$];
  logic [8:0] chq[4][$];
  int         tc[$];
  int         total = 0, bad = 0, cyc = 0;
  bit         ok;

  merge_fifo_nway #(.DW(8), .NCH(4), .CHW(2), .FIFO_DEPTH_WIDTH(4), .DEDUP(1'b1)) u_a (
    .clk(clk), .reset(rst_n), .i_valid(v4), .i_ready(ra), .i_last(l4), .i_data(d4),
    .o_ready(ora), .o_valid(va), .o_last(la), .o_data(da), .o_ch(cha), .o_mask(ma),
    .o_cnt(ca), .o_level(lva)
  );
  merge_fifo_nway #(.DW(8), .NCH(4), .CHW(2), .FIFO_DEPTH_WIDTH(4), .DEDUP(1'b0)) u_b (
    .clk(clk), .reset(rst_n), .i_valid(v4), .i_ready(rb), .i_last(l4), .i_data(d4),
    .o_ready(orb), .o_valid(vb), .o_last(lb), .o_data(db), .o_ch(chb), .o_mask(mb),
    .o_cnt(cb), .o_level(lvb)
  );
  merge_fifo_nway #(.DW(8), .NCH(2), .CHW(1), .FIFO_DEPTH_WIDTH(4), .DEDUP(1'b1)) u_c (
    .clk(clk), .reset(rst_n), .i_valid(v2), .i_ready(rc), .i_last(l2), .i_data(d2),
    .o_ready(orc), .o_valid(vc), .o_last(lc), .o_data(dc), .o_ch(chc), .o_mask(mc),
    .o_cnt(cc), .o_level(lvc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t bt(input logic [7:0] d, input logic [3:0] m, input logic [2:0] n,
                               input logic [1:0] ch, input logic l);
    bt = '{d: d, m: m, n: n, ch: ch, l: l};
  endfunction

  // Monitors sample at negedge: valid & ready here means the beat is taken next edge.
  always @(negedge clk) begin : mon_a
    beat_t e;
    if (rst_n && va) begin
      if (qa.size() == 0) check("a_unexpected_beat", qa.size(), 1);
      else if (ora) begin
        e = qa.pop_front();
        check("a_data", da, e.d); check("a_mask", ma, e.m); check("a_cnt", ca, e.n);
        check("a_ch", cha, e.ch); check("a_last", la, e.l);
      end else begin
        check("a_hold_data", da, qa[0].d); check("a_hold_mask", ma, qa[0].m);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    beat_t e;
    if (rst_n && vb && orb) begin
      if (qb.size() == 0) check("b_unexpected_beat", qb.size(), 1);
      else begin
        e = qb.pop_front();
        check("b_data", db, e.d); check("b_mask", mb, e.m); check("b_cnt", cb, e.n);
        check("b_ch", chb, e.ch); check("b_last", lb, e.l);
      end
    end
  end

  always @(negedge clk) begin : mon_c
    beat_t e;
    if (rst_n && vc && orc) begin
      if (qc.size() == 0) check("c_unexpected_beat", qc.size(), 1);
      else begin
        e = qc.pop_front();
        tc.push_back(cyc);
        check("c_data", dc, e.d); check("c_mask", mc, e.m); check("c_cnt", cc, e.n);
        check("c_ch", chc, e.ch); check("c_last", lc, e.l);
      end
    end
  end

  task automatic put(input int c, input logic l, input logic [7:0] d);
    chq[c].push_back({l, d});
  endtask

  // Offers each channel queue head while the DUT(s) are ready; done=1 once all queues empty.
  task automatic drive(input bit two, input int max_cycles, output bit done);
    logic [3:0] v, rdy;
    done = 1'b0;
    for (int n = 0; n < max_cycles; n++) begin
      if (chq[0].size() + chq[1].size() + chq[2].size() + chq[3].size() == 0) begin
        done = 1'b1;
        break;
      end
      rdy = two ? {2'b00, rc} : (ra & rb);
      v = '0;
      for (int c = 0; c < 4; c++) begin
        if (chq[c].size() != 0 && rdy[c]) begin
          v[c] = 1'b1;
          if (two) begin d2[c*8 +: 8] = chq[c][0][7:0]; l2[c] = chq[c][0][8]; end
          else     begin d4[c*8 +: 8] = chq[c][0][7:0]; l4[c] = chq[c][0][8]; end
        end
      end
      if (two) v2 = v[1:0]; else v4 = v;
      @(posedge clk); #1;
      for (int c = 0; c < 4; c++) if (v[c]) void'(chq[c].pop_front());
    end
    v4 = '0;
    v2 = '0;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    for (int n = 0; n < max_cycles && (qa.size() + qb.size() + qc.size()) != 0; n++) begin
      @(posedge clk); #1;
    end
    check(tag, qa.size() + qb.size() + qc.size(), 0);
  endtask

  task automatic load_group1();
    put(0, 0, 8'h10); put(0, 0, 8'h14); put(0, 1, 8'h18);
    put(1, 0, 8'h02); put(1, 1, 8'h14);
    put(2, 1, 8'h03);
    put(3, 0, 8'h18); put(3, 1, 8'h1f);
    qa.push_back(bt(8'h02, 4'b0010, 3'd1, 2'd1, 1'b0));
    qa.push_back(bt(8'h03, 4'b0100, 3'd1, 2'd2, 1'b0));
    qa.push_back(bt(8'h10, 4'b0001, 3'd1, 2'd0, 1'b0));
    qa.push_back(bt(8'h14, 4'b0011, 3'd2, 2'd0, 1'b0));
    qa.push_back(bt(8'h18, 4'b1001, 3'd2, 2'd0, 1'b0));
    qa.push_back(bt(8'h1f, 4'b1000, 3'd1, 2'd3, 1'b1));
    qb.push_back(bt(8'h02, 4'b0010, 3'd1, 2'd1, 1'b0));
    qb.push_back(bt(8'h03, 4'b0100, 3'd1, 2'd2, 1'b0));
    qb.push_back(bt(8'h10, 4'b0001, 3'd1, 2'd0, 1'b0));
    qb.push_back(bt(8'h14, 4'b0001, 3'd1, 2'd0, 1'b0));
    qb.push_back(bt(8'h14, 4'b0010, 3'd1, 2'd1, 1'b0));
    qb.push_back(bt(8'h18, 4'b0001, 3'd1, 2'd0, 1'b0));
    qb.push_back(bt(8'h18, 4'b1000, 3'd1, 2'd3, 1'b0));
    qb.push_back(bt(8'h1f, 4'b1000, 3'd1, 2'd3, 1'b1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; v4 = '0; l4 = '0; d4 = '0; v2 = '0; l2 = '0; d2 = '0;
    ora = 1'b1; orb = 1'b1; orc = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {va, vb, vc}, 0);
    check("rst_data", {da, ma, ca, cha, la}, 0);
    check("rst_level", {lva, lvc}, 0);
    check("rst_ready", {ra, rc}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", {ra, rc}, 6'h3f);

    // Single group, dedup and non-dedup side by side
    load_group1();
    drive(1'b0, 50, ok);
    check("g1_drive_done", ok, 1);
    drain("g1_drain", 100);

    // Back-pressure mid-group on the dedup instance
    load_group1();
    drive(1'b0, 50, ok);
    check("bp_drive_done", ok, 1);
    for (int n = 0; n < 50 && qa.size() > 3; n++) begin @(posedge clk); #1; end
    ora = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    ora = 1'b1;
    drain("bp_drain", 100);

    // Reset after three beats; then a fresh group
    load_group1();
    drive(1'b0, 50, ok);
    for (int n = 0; n < 50 && qa.size() > 3; n++) begin @(posedge clk); #1; end
    check("mid_level_nonzero", (lva != 0), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_outputs", {va, la, da, ma, ca, cha}, 0);
    check("mid_rst_level", {lva, lvb}, 0);
    check("mid_rst_ready", {ra, rb}, 0);
    qa.delete(); qb.delete(); qc.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_group1();
    drive(1'b0, 50, ok);
    check("post_rst_drive_done", ok, 1);
    drain("post_rst_drain", 100);

    // Full/stall: channel 1 idle while channel 0 fills
    for (int i = 0; i < 20; i++) put(0, (i == 19), 8'(8'h10 + i));
    drive(1'b1, 24, ok);
    check("full_accepts_left", chq[0].size(), 4);
    check("full_ready0", rc[0], 0);
    check("full_level0", lvc[4:0], 16);
    check("full_no_valid", vc, 0);
    qc.push_back(bt(8'h00, 4'b0010, 3'd1, 2'd1, 1'b0));
    for (int i = 0; i < 20; i++)
      qc.push_back(bt(8'(8'h10 + i), 4'b0001, 3'd1, 2'd0, (i == 19)));
    put(1, 1, 8'h00);
    drive(1'b1, 100, ok);
    check("full_drive_done", ok, 1);
    drain("full_drain", 100);

    // Back-to-back groups with no bubble at the boundary
    tc.delete();
    put(0, 1, 8'h05); put(0, 1, 8'h07);
    put(1, 1, 8'h06); put(1, 1, 8'h01);
    qc.push_back(bt(8'h05, 4'b0001, 3'd1, 2'd0, 1'b0));
    qc.push_back(bt(8'h06, 4'b0010, 3'd1, 2'd1, 1'b1));
    qc.push_back(bt(8'h01, 4'b0010, 3'd1, 2'd1, 1'b0));
    qc.push_back(bt(8'h07, 4'b0001, 3'd1, 2'd0, 1'b1));
    drive(1'b1, 50, ok);
    check("b2b_drive_done", ok, 1);
    drain("b2b_drain", 100);
    check("b2b_beats", tc.size(), 4);
    if (tc.size() == 4) begin
      check("b2b_gap01", tc[1] - tc[0], 1);
      check("b2b_gap12", tc[2] - tc[1], 1);
      check("b2b_gap23", tc[3] - tc[2], 1);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
